speed_switch_ctrl: RTL and testbench

Parametrised CPU speed controller. It replaces per-speed derived clocks and a clock mux with a single-clock design that produces a clock-enable strobe.
- The CPU programs a KEY1-style register to arm a switch, then executes STOP.
- On STOP, the block suppresses CPU enables for a drain window, loads the new speed, and resumes.
- It supports up to 8 speed levels and a legacy CGB toggle mode.
- It sits beside the memory router on the IO register bus and feeds the CE of the CPU and peripherals.

---
 rtl/speed_switch_pkg.sv | 30 +++
 rtl/speed_switch_ctrl_ce_divider.sv | 31 +++
 rtl/speed_switch_ctrl.sv | 134 +++++++++++++
 tb/tb_speed_switch_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_switch_pkg.sv
// Shared definitions for the speed switch controller: FSM states, KEY1
// register field layout and the speed field width.
package speed_switch_pkg;

  localparam int unsigned SPEED_W        = 3;
  localparam int unsigned KEY1_ARMED_BIT = 0;
  localparam int unsigned KEY1_TGT_LSB   = 1;
  localparam int unsigned KEY1_SPD_LSB   = 4;
  localparam int unsigned KEY1_FAST_BIT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DRAIN,
    ST_SWITCH
  } state_e;

  function automatic logic [7:0] key1_pack(input logic [SPEED_W-1:0] spd,
                                           input logic [SPEED_W-1:0] tgt,
                                           input logic               armed);
    logic [7:0] r;
    r                               = '0;
    r[KEY1_FAST_BIT]                = |spd;
    r[KEY1_SPD_LSB +: SPEED_W]      = spd;
    r[KEY1_TGT_LSB +: SPEED_W]      = tgt;
    r[KEY1_ARMED_BIT]               = armed;
    return r;
  endfunction

endpackage

// File: rtl/speed_switch_ctrl_ce_divider.sv
// Variable-period clock-enable generator: one-cycle ce every period_i cycles,
// counter parked at zero while hold_i is high.
module ce_divider #(
  parameter int unsigned P_W = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [P_W-1:0] period_i,
  input  logic           hold_i,
  output logic           ce_o
);

  logic [P_W-1:0] cnt_q, cnt_d;
  logic           at_end;

  // >= rather than == so a shortened period can never strand the counter
  assign at_end = (cnt_q >= period_i - P_W'(1));

  always_comb begin
    cnt_d = cnt_q + P_W'(1);
    if (hold_i || at_end) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign ce_o = !hold_i && at_end;

endmodule

// File: rtl/speed_switch_ctrl.sv
// Single-clock CPU speed controller: KEY1-style register arms a switch, STOP
// drains the CPU enables for a fixed window, then the new speed is loaded.
module speed_switch_ctrl
  import speed_switch_pkg::*;
#(
  parameter int unsigned P_NUM_SPEEDS    = 2,
  parameter int unsigned P_BASE_DIV      = 8,
  parameter int unsigned P_COUNTDOWN     = 255,
  parameter int unsigned P_CNT_W         = 16,
  parameter logic [15:0] P_REG_ADDR      = 16'hFF4D,
  parameter bit          P_LEGACY_TOGGLE = 1'b1
) (
  input  logic         I_CLK,
  input  logic         I_SYNC_RESET,
  input  logic [15:0]  I_IOREG_ADDR,
  inout  wire  [7:0]   IO_IOREG_DATA,
  input  logic         I_IOREG_WE_L,
  input  logic         I_IOREG_RE_L,
  input  logic         I_STOP_EXEC,
  output logic         O_CPU_CE,
  output logic [2:0]   O_SPEED,
  output logic         O_SWITCH_BUSY,
  output logic         O_SWITCH_DONE,
  output logic [7:0]   O_KEY1_DATA
);

  localparam int unsigned        DIV_W     = $clog2(P_BASE_DIV + 1);
  localparam logic [SPEED_W-1:0] MAX_SPEED = SPEED_W'(P_NUM_SPEEDS - 1);

  state_e               state_q, state_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic [SPEED_W-1:0]   target_q, target_d;
  logic                 armed_q, armed_d;
  logic [P_CNT_W-1:0]   count_q, count_d;
  logic                 done_q, done_d;

  logic                 wr_hit, rd_hit, wr_arm, hold;
  logic [SPEED_W-1:0]   wr_field, wr_target;
  logic [DIV_W-1:0]     period;

  assign wr_hit   = (I_IOREG_ADDR == P_REG_ADDR) && !I_IOREG_WE_L;
  assign rd_hit   = (I_IOREG_ADDR == P_REG_ADDR) && !I_IOREG_RE_L;
  assign wr_arm   = IO_IOREG_DATA[KEY1_ARMED_BIT];
  assign wr_field = IO_IOREG_DATA[KEY1_TGT_LSB +: SPEED_W];

  assign O_KEY1_DATA   = key1_pack(speed_q, target_q, armed_q);
  assign IO_IOREG_DATA = rd_hit ? O_KEY1_DATA : 8'bz;

  always_comb begin
    wr_target = (wr_field > MAX_SPEED) ? MAX_SPEED : wr_field;
    if (P_LEGACY_TOGGLE) wr_target = (speed_q == '0) ? MAX_SPEED : '0;
  end

  always_comb begin
    state_d  = state_q;
    speed_d  = speed_q;
    target_d = target_q;
    armed_d  = armed_q;
    count_d  = count_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_hit) begin
          armed_d  = wr_arm;
          target_d = wr_target;
          if (wr_arm) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (I_STOP_EXEC) begin
          if (target_q != speed_q) begin
            state_d = ST_DRAIN;
            count_d = P_CNT_W'(P_COUNTDOWN);
          end else begin
            state_d  = ST_IDLE;
            armed_d  = 1'b0;
            target_d = '0;
            done_d   = 1'b1;
          end
        end else if (wr_hit) begin
          armed_d  = wr_arm;
          target_d = wr_target;
          if (!wr_arm) state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (count_q == '0) state_d = ST_SWITCH;
        else               count_d = count_q - P_CNT_W'(1);
      end
      ST_SWITCH: begin
        // completion retires the request, so KEY1 reads back speed-only
        speed_d  = target_q;
        target_d = '0;
        armed_d  = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RESET) begin
      state_q  <= ST_IDLE;
      speed_q  <= '0;
      target_q <= '0;
      armed_q  <= 1'b0;
      count_q  <= P_CNT_W'(P_COUNTDOWN);
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      target_q <= target_d;
      armed_q  <= armed_d;
      count_q  <= count_d;
      done_q   <= done_d;
    end
  end

  assign hold   = state_q inside {ST_DRAIN, ST_SWITCH};
  assign period = DIV_W'(P_BASE_DIV >> speed_q);

  ce_divider #(.P_W(DIV_W)) u_ce_div (
    .clk_i    (I_CLK),
    .rst_i    (I_SYNC_RESET),
    .period_i (period),
    .hold_i   (hold),
    .ce_o     (O_CPU_CE)
  );

  assign O_SPEED       = speed_q;
  assign O_SWITCH_BUSY = (state_q == ST_DRAIN);
  assign O_SWITCH_DONE = (state_q == ST_SWITCH) || done_q;

endmodule

// File: tb/tb_speed_switch_ctrl.sv
// Bench for speed_switch_ctrl: a legacy two-speed instance and a four-speed
// non-legacy instance, CE timing and register reads checked through queues.
module tb_speed_switch_ctrl;

  localparam logic [15:0] KEY1 = 16'hFF4D;
  localparam int          CD1  = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr [2];
  logic        we_l [2], re_l [2], stop [2], den [2];
  logic [7:0]  drv  [2];
  wire  [7:0]  bus0, bus1;
  logic        ce [2], busy [2], done [2];
  logic [2:0]  spd [2];
  logic [7:0]  key [2];

  int unsigned cyc = 0;
  int          checks = 0, errors = 0;
  int unsigned ceq [$];
  logic [7:0]  rdq [$];
  int          mon_sel = 0;
  bit          mon_en = 1'b0;
  int unsigned ce_end;

  typedef struct {
    int          d;
    logic [15:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl [11];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus0 = den[0] ? drv[0] : 8'bz;
  assign bus1 = den[1] ? drv[1] : 8'bz;

  speed_switch_ctrl dut0 (
    .I_CLK(clk), .I_SYNC_RESET(rst), .I_IOREG_ADDR(addr[0]), .IO_IOREG_DATA(bus0),
    .I_IOREG_WE_L(we_l[0]), .I_IOREG_RE_L(re_l[0]), .I_STOP_EXEC(stop[0]),
    .O_CPU_CE(ce[0]), .O_SPEED(spd[0]), .O_SWITCH_BUSY(busy[0]),
    .O_SWITCH_DONE(done[0]), .O_KEY1_DATA(key[0])
  );

  speed_switch_ctrl #(
    .P_NUM_SPEEDS(4), .P_BASE_DIV(8), .P_COUNTDOWN(CD1), .P_LEGACY_TOGGLE(1'b0)
  ) dut1 (
    .I_CLK(clk), .I_SYNC_RESET(rst), .I_IOREG_ADDR(addr[1]), .IO_IOREG_DATA(bus1),
    .I_IOREG_WE_L(we_l[1]), .I_IOREG_RE_L(re_l[1]), .I_STOP_EXEC(stop[1]),
    .O_CPU_CE(ce[1]), .O_SPEED(spd[1]), .O_SWITCH_BUSY(busy[1]),
    .O_SWITCH_DONE(done[1]), .O_KEY1_DATA(key[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input logic [15:0] a, input logic [7:0] v);
    addr[d] = a; drv[d] = v; den[d] = 1'b1; we_l[d] = 1'b0;
    tick();
    we_l[d] = 1'b1; den[d] = 1'b0; addr[d] = 16'h0000;
  endtask

  task automatic rd(input int d, input logic [7:0] exp, input string name);
    chk({name, "_key1"}, key[d], exp);
    rdq.push_back(exp);
    addr[d] = KEY1; re_l[d] = 1'b0;
    tick();
    re_l[d] = 1'b1; addr[d] = 16'h0000;
  endtask

  task automatic ce_open(input int d, input int unsigned first, input int unsigned period,
                         input int n);
    mon_sel = d;
    ceq.delete();
    for (int j = 0; j < n; j++) ceq.push_back(first + j * period);
    ce_end = first + (n - 1) * period + 1;
    mon_en = 1'b1;
  endtask

  task automatic ce_close(input string name);
    mon_en = 1'b0;
    chk({name, "_ce_missing"}, ceq.size(), 0);
  endtask

  task automatic run_stop(input int d, input int busy_len, input bit exp_done,
                          input int unsigned period, input logic [2:0] exp_spd,
                          input string tag);
    int unsigned stop_cyc, s, done_cyc, stop_at;
    int          nbusy, ndone;
    stop_cyc = cyc;
    stop[d] = 1'b1;
    tick();
    stop[d] = 1'b0;
    s = cyc;
    nbusy = 0; ndone = 0; done_cyc = 0;
    if (busy_len > 0) begin
      ce_open(d, s + busy_len + period, period, 4);
      stop_at = ce_end;
    end else begin
      stop_at = s + 8;
    end
    while (cyc < stop_at) begin
      if (busy[d]) nbusy++;
      if (done[d]) begin ndone++; done_cyc = cyc; end
      tick();
    end
    if (busy_len > 0) ce_close(tag);
    chk({tag, "_busy_cycles"}, nbusy, busy_len);
    chk({tag, "_done_pulses"}, ndone, int'(exp_done));
    if (exp_done) chk({tag, "_done_latency"}, done_cyc - stop_cyc, (busy_len > 0) ? busy_len + 1 : 1);
    chk({tag, "_speed"}, spd[d], exp_spd);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int unsigned r, s;
    int          n;

    tbl[0]  = '{0, KEY1,     8'h01, 8'h03};
    tbl[1]  = '{0, 16'hFF4C, 8'h00, 8'h03};
    tbl[2]  = '{0, KEY1,     8'hFE, 8'h02};
    tbl[3]  = '{0, KEY1,     8'h0F, 8'h03};
    tbl[4]  = '{0, KEY1,     8'h00, 8'h02};
    tbl[5]  = '{1, KEY1,     8'h0F, 8'h07};
    tbl[6]  = '{1, KEY1,     8'h0A, 8'h06};
    tbl[7]  = '{1, KEY1,     8'h04, 8'h04};
    tbl[8]  = '{1, KEY1,     8'h05, 8'h05};
    tbl[9]  = '{1, 16'hFFFF, 8'h0F, 8'h05};
    tbl[10] = '{1, KEY1,     8'h00, 8'h00};

    for (int d = 0; d < 2; d++) begin
      addr[d] = 16'h0000; we_l[d] = 1'b1; re_l[d] = 1'b1;
      stop[d] = 1'b0; den[d] = 1'b0; drv[d] = 8'h00;
    end
    rst = 1'b1;

    fork
      forever begin
        logic [7:0] bv;
        @(negedge clk);
        if (mon_en && ce[mon_sel]) begin
          if (ceq.size() == 0) begin
            checks++; errors++;
            $display("FAIL ce_unexpected: dut%0d ce at cycle %0d, required none", mon_sel, cyc);
          end else begin
            chk("ce_cycle", cyc, ceq.pop_front());
          end
        end
        for (int d = 0; d < 2; d++) begin
          if (!re_l[d]) begin
            bv = (d == 0) ? bus0 : bus1;
            if (rdq.size() == 0) begin
              checks++; errors++;
              $display("FAIL read_unexpected: dut%0d bus 0x%0h, required no read", d, bv);
            end else begin
              chk("read_bus", bv, rdq.pop_front());
            end
          end
        end
      end
    join_none

    // reset and defaults
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset_ce", ce[d], 0);
      chk("reset_busy", busy[d], 0);
      chk("reset_done", done[d], 0);
      chk("reset_speed", spd[d], 0);
    end
    rst = 1'b0;
    r = cyc;
    ce_open(0, r + 7, 8, 4);
    while (cyc < ce_end) tick();
    ce_close("reset_period8");
    rd(0, 8'h00, "reset_read0");
    rd(1, 8'h00, "reset_read1");

    // register write/readback vectors
    for (int i = 0; i < 11; i++) begin
      wr(tbl[i].d, tbl[i].a, tbl[i].wd);
      rd(tbl[i].d, tbl[i].exp, $sformatf("table%0d", i));
    end

    // legacy toggle up and back down
    wr(0, KEY1, 8'h01);
    rd(0, 8'h03, "legacy_armed");
    run_stop(0, 256, 1'b1, 4, 3'd1, "legacy_up");
    rd(0, 8'h90, "legacy_up_read");
    wr(0, KEY1, 8'h01);
    rd(0, 8'h91, "legacy_rearm");
    run_stop(0, 256, 1'b1, 8, 3'd0, "legacy_down");
    rd(0, 8'h00, "legacy_down_read");

    // multi-speed instance: jump to top speed, then clamped same-speed request
    wr(1, KEY1, 8'h07);
    rd(1, 8'h07, "ms_armed");
    run_stop(1, CD1 + 1, 1'b1, 1, 3'd3, "ms_up");
    rd(1, 8'hB0, "ms_up_read");
    wr(1, KEY1, 8'h0F);
    rd(1, 8'hB7, "ms_clamp");
    run_stop(1, 0, 1'b1, 1, 3'd3, "ms_same");
    rd(1, 8'hB0, "ms_same_read");

    // disarm, then STOP with nothing armed
    wr(0, KEY1, 8'h01);
    wr(0, KEY1, 8'h00);
    rd(0, 8'h02, "disarm_read");
    run_stop(0, 0, 1'b0, 8, 3'd0, "disarm_stop");
    run_stop(0, 0, 1'b0, 8, 3'd0, "idle_stop");

    // write colliding with STOP, write during drain
    wr(0, KEY1, 8'h01);
    addr[0] = KEY1; drv[0] = 8'h00; den[0] = 1'b1; we_l[0] = 1'b0; stop[0] = 1'b1;
    tick();
    we_l[0] = 1'b1; den[0] = 1'b0; stop[0] = 1'b0; addr[0] = 16'h0000;
    chk("collide_busy", busy[0], 1);
    rd(0, 8'h03, "collide_write_dropped");
    repeat (5) tick();
    wr(0, KEY1, 8'h00);
    rd(0, 8'h03, "drain_write_ignored");
    chk("drain_busy_after_write", busy[0], 1);
    n = 0;
    while (!done[0] && n < 400) begin tick(); n++; end
    chk("collide_done_seen", done[0], 1);
    tick();
    chk("collide_speed", spd[0], 1);

    // reset in the middle of a drain
    wr(0, KEY1, 8'h01);
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
    s = cyc;
    while (cyc < s + 155) tick();
    chk("middrain_busy", busy[0], 1);
    rst = 1'b1;
    tick();
    chk("middrain_reset_busy", busy[0], 0);
    chk("middrain_reset_speed", spd[0], 0);
    chk("middrain_reset_key1", key[0], 8'h00);
    chk("middrain_reset_speed_ms", spd[1], 0);
    rst = 1'b0;
    r = cyc;
    ce_open(0, r + 7, 8, 4);
    while (cyc < ce_end) tick();
    ce_close("middrain_period8");
    chk("read_queue_drained", rdq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
